// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the five-digit segment scan controller:
// display mode codes, slot FSM encoding, the blank glyph and small
// glyph/digit helper functions.
package seg_scan_ctrl_pkg;

  localparam int unsigned NUM_DIGITS = 5;

  // Display mode codes as seen on mode_in. Code 11 behaves like constant.
  typedef enum logic [1:0] {
    SEG_MODE_CONST     = 2'b00,
    SEG_MODE_FLASH     = 2'b01,
    SEG_MODE_OFF       = 2'b10,
    SEG_MODE_CONST_ALT = 2'b11
  } seg_mode_e;

  // Segment pattern driven whenever nothing should light.
  localparam logic [7:0] SEG_BLANK_GLYPH = 8'h00;

  // Per-slot phase: anti-ghost blanking, then digit drive.
  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_e;

  // One-hot digit enable for digit index 0..4.
  function automatic logic [4:0] digit_onehot(input logic [2:0] digit);
    return 5'b00001 << digit;
  endfunction

  // Digit 0 lives in the most significant byte of the frame word.
  function automatic logic [7:0] pick_glyph(input logic [39:0] frame,
                                            input logic [2:0]  digit);
    logic [7:0] glyph;
    glyph = SEG_BLANK_GLYPH;
    case (digit)
      3'd0:    glyph = frame[39:32];
      3'd1:    glyph = frame[31:24];
      3'd2:    glyph = frame[23:16];
      3'd3:    glyph = frame[15:8];
      3'd4:    glyph = frame[7:0];
      default: glyph = SEG_BLANK_GLYPH;
    endcase
    return glyph;
  endfunction

  // Whether the active mode lets the glyph through in the current flash phase.
  function automatic logic mode_shows(input seg_mode_e mode, input logic flash_on);
    logic show;
    case (mode)
      SEG_MODE_FLASH: show = flash_on;
      SEG_MODE_OFF:   show = 1'b0;
      default:        show = 1'b1;
    endcase
    return show;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_slot_timer.sv
// Slot timer for the segment scanner: a BLANK/DRIVE FSM paced by a slot
// counter, advancing the digit index 0..4 and flagging the end of a frame.
// BLANK_CYC is expected to be at least 1.
module seg_slot_timer
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 20000,
  parameter int BLANK_CYC = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] digit_o,
  output logic       drive_o,
  output logic       frame_done_o
);

  // One counter spans the whole slot, so it never exceeds SCAN_DIV-1.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);

  slot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;

  // State register: slot phase, position within the slot, digit index.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_BLANK;
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  // Next-state logic: BLANK hands over to DRIVE mid-slot, DRIVE ends the slot.
  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    unique case (state_q)
      SLOT_BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = SLOT_DRIVE;
      end
      SLOT_DRIVE: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = SLOT_BLANK;
          cnt_d   = '0;
          digit_d = (digit_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : digit_q + 3'd1;
        end
      end
      default: state_d = SLOT_BLANK;
    endcase
  end

  // Outputs: drive flag, digit index, and the frame-end pulse on the 4->0 wrap.
  always_comb begin
    digit_o      = digit_q;
    drive_o      = (state_q == SLOT_DRIVE);
    frame_done_o = (state_q == SLOT_DRIVE) && (cnt_q == SLOT_LAST) &&
                   (digit_q == 3'(NUM_DIGITS - 1));
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Five-digit multiplexed seven-segment scan controller with a double-buffered
// frame (shadow -> active on frame boundaries), constant/flash/off modes.
// Optional feature: define SEG_DIM_EN to add the bright[1:0] input and
// quarter-step duty dimming of the DRIVE phase.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 20000,
  parameter int BLANK_CYC    = 200,
  parameter int FLASH_FRAMES = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] data_in,
  input  logic [1:0]  mode_in,
  input  logic        load,
`ifdef SEG_DIM_EN
  input  logic [1:0]  bright,
`endif
  output logic        ready,
  output logic [4:0]  seg_select,
  output logic [7:0]  seg_out,
  output logic        frame_done
);

  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_FRAMES - 1);

  logic [2:0] digit;
  logic       drive;
  logic       xfer;
  logic       dim_en;

  logic [39:0]        shadow_data_q, shadow_data_d;
  seg_mode_e          shadow_mode_q, shadow_mode_d;
  logic               shadow_full_q, shadow_full_d;
  logic [39:0]        active_data_q, active_data_d;
  seg_mode_e          active_mode_q, active_mode_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               flash_on_q, flash_on_d;

  seg_slot_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk          (clk),
    .rst_n        (reset),
    .digit_o      (digit),
    .drive_o      (drive),
    .frame_done_o (frame_done)
  );

`ifdef SEG_DIM_EN
  localparam int DRIVE_CYC = SCAN_DIV - BLANK_CYC;
  localparam int DIM_W     = $clog2(DRIVE_CYC + 1);

  logic [1:0]       bright_q;
  logic             drive_q;
  logic [DIM_W-1:0] dim_cnt_q;
  logic [31:0]      dim_limit;

  // Capture brightness on the first BLANK cycle of a slot and count DRIVE cycles.
  // drive_q resets high so the first slot after reset also counts as a BLANK entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bright_q  <= '0;
      drive_q   <= 1'b1;
      dim_cnt_q <= '0;
    end else begin
      drive_q   <= drive;
      if (!drive && drive_q) bright_q <= bright;
      dim_cnt_q <= drive ? dim_cnt_q + 1'b1 : '0;
    end
  end

  assign dim_limit = ((32'(bright_q) + 32'd1) * 32'(DRIVE_CYC)) >> 2;
  assign dim_en    = (32'(dim_cnt_q) < dim_limit);
`else
  assign dim_en = 1'b1;
`endif

  assign ready = ~shadow_full_q;
  assign xfer  = frame_done && shadow_full_q;

  // Buffer and flash-phase next state: load fills an empty shadow, frame end
  // promotes a full shadow, and a mode change on promotion restarts flashing.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_mode_d = shadow_mode_q;
    shadow_full_d = shadow_full_q;
    active_data_d = active_data_q;
    active_mode_d = active_mode_q;
    flash_cnt_d   = flash_cnt_q;
    flash_on_d    = flash_on_q;

    if (xfer) begin
      active_data_d = shadow_data_q;
      active_mode_d = shadow_mode_q;
      shadow_full_d = 1'b0;
    end

    // ready and xfer are mutually exclusive, so a load on the frame-end cycle
    // lands in the shadow and waits for the following frame end.
    if (load && !shadow_full_q) begin
      shadow_data_d = data_in;
      shadow_mode_d = seg_mode_e'(mode_in);
      shadow_full_d = 1'b1;
    end

    if (xfer && (shadow_mode_q != active_mode_q)) begin
      flash_cnt_d = '0;
      flash_on_d  = 1'b1;
    end else if (frame_done) begin
      if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = '0;
        flash_on_d  = ~flash_on_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end
  end

  // Buffer and flash-phase registers.
  // NOTE: the frame buffers are reset explicitly because a cleared display and an empty shadow after reset are required behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_data_q <= '0;
      shadow_mode_q <= SEG_MODE_CONST;
      shadow_full_q <= 1'b0;
      active_data_q <= '0;
      active_mode_q <= SEG_MODE_CONST;
      flash_cnt_q   <= '0;
      flash_on_q    <= 1'b1;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_mode_q <= shadow_mode_d;
      shadow_full_q <= shadow_full_d;
      active_data_q <= active_data_d;
      active_mode_q <= active_mode_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_on_q    <= flash_on_d;
    end
  end

  // Digit drive: select stays one-hot through DRIVE; segments gated by mode and duty.
  always_comb begin
    seg_select = '0;
    seg_out    = SEG_BLANK_GLYPH;
    if (drive) begin
      seg_select = digit_onehot(digit);
      if (mode_shows(active_mode_q, flash_on_q) && dim_en)
        seg_out = pick_glyph(active_data_q, digit);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (SCAN_DIV=16, BLANK_CYC=4,
// FLASH_FRAMES=2). A cycle-count based reference model predicts every
// output on every cycle; directed steps add explicit checks.
module tb_seg_scan_ctrl;

  localparam int SD    = 16;
  localparam int BC    = 4;
  localparam int FF    = 2;
  localparam int FRAME = 5 * SD;
  localparam int DRV   = SD - BC;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [39:0] data_in = '0;
  logic [1:0]  mode_in = '0;
  logic        load    = 1'b0;
  logic        ready;
  logic [4:0]  seg_select;
  logic [7:0]  seg_out;
  logic        frame_done;
`ifdef SEG_DIM_EN
  logic [1:0]  bright  = 2'b01;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: cycles since reset release, buffers, frame count
  // since the last mode change (flash phase follows from it arithmetically).
  int          t;
  logic [39:0] m_active, m_shadow;
  logic [1:0]  m_amode, m_smode;
  bit          m_full;
  int          m_frames;
  logic [1:0]  m_bright;

  seg_scan_ctrl #(
    .SCAN_DIV     (SD),
    .BLANK_CYC    (BC),
    .FLASH_FRAMES (FF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .mode_in    (mode_in),
    .load       (load),
`ifdef SEG_DIM_EN
    .bright     (bright),
`endif
    .ready      (ready),
    .seg_select (seg_select),
    .seg_out    (seg_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    m_active = '0;
    m_shadow = '0;
    m_amode  = 2'b00;
    m_smode  = 2'b00;
    m_full   = 1'b0;
    m_frames = 0;
    m_bright = 2'b00;
  endtask

  task automatic compare();
    int         pos, dig;
    bit         drv, show;
    logic [4:0] e_sel;
    logic [7:0] e_seg;
    pos  = t % SD;
    dig  = (t / SD) % 5;
    drv  = (pos >= BC);
    if (m_amode == 2'b10)      show = 1'b0;
    else if (m_amode == 2'b01) show = ((m_frames / FF) % 2) == 0;
    else                       show = 1'b1;
`ifdef SEG_DIM_EN
    if ((pos - BC) >= ((int'(m_bright) + 1) * DRV) / 4) show = 1'b0;
`endif
    e_sel = drv ? 5'(1 << dig) : 5'd0;
    e_seg = (drv && show) ? 8'(m_active >> (8 * (4 - dig))) : 8'h00;
    check("seg_select", 64'(seg_select), 64'(e_sel));
    check("seg_out",    64'(seg_out),    64'(e_seg));
    check("frame_done", 64'(frame_done), 64'((t % FRAME) == FRAME - 1));
    check("ready",      64'(ready),      64'(!m_full));
  endtask

  task automatic model_edge();
    bit fd, full0;
    fd    = (t % FRAME) == FRAME - 1;
    full0 = m_full;
`ifdef SEG_DIM_EN
    if ((t % SD) == 0) m_bright = bright;
`endif
    if (fd) begin
      if (full0) begin
        if (m_smode != m_amode) m_frames = 0;
        else                    m_frames++;
        m_active = m_shadow;
        m_amode  = m_smode;
        m_full   = 1'b0;
      end else begin
        m_frames++;
      end
    end
    if (load && !full0) begin
      m_shadow = data_in;
      m_smode  = mode_in;
      m_full   = 1'b1;
    end
    t++;
  endtask

  // One clock: check at the falling edge, advance the model, settle past the rising edge.
  task automatic tick();
    @(negedge clk);
    compare();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_to(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) tick();
  endtask

  task automatic load_frame(input logic [39:0] d, input logic [1:0] m);
    data_in = d;
    mode_in = m;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  initial begin
    int nz;
    model_reset();

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_seg_select", 64'(seg_select), 64'h0);
    check("rst_seg_out",    64'(seg_out),    64'h0);
    check("rst_frame_done", 64'(frame_done), 64'h0);
    check("rst_ready",      64'(ready),      64'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();

    // Basic load, then a load while not ready that must be ignored
    load_frame(40'h3F_06_5B_4F_66, 2'b00);
    check("ready_low_after_load", 64'(ready), 64'h0);
    load_frame(40'hFF_FF_FF_FF_FF, 2'b00);
    advance_to(FRAME - 1);
    check("frame_done_at_79", 64'(frame_done), 64'h1);
    tick();
    check("ready_after_xfer", 64'(ready), 64'h1);
`ifdef SEG_DIM_EN
    nz = 0;
    for (int i = 0; i < SD; i++) begin
      if (seg_out != 8'h00) nz++;
      tick();
    end
    check("dim_nonzero_cycles", 64'(nz), 64'd6);
`endif
    advance_to(2 * SD + BC);
    check("digit2_select", 64'(seg_select), 64'h04);
    check("digit2_glyph",  64'(seg_out),    64'h5B);
    advance_to(3 * SD + BC);
    check("ignored_load_digit3", 64'(seg_out), 64'h4F);

    // Flash mode: on two frames, off two frames, on again
    load_frame(40'h7F_6D_66_4F_5B, 2'b01);
    advance_to(FRAME - 1);
    tick();
    for (int k = 0; k < 5; k++) begin
      advance_to(BC);
      check("flash_select", 64'(seg_select), 64'h01);
      check("flash_glyph",  64'(seg_out), (k == 2 || k == 3) ? 64'h00 : 64'h7F);
      advance_to(FRAME - 1);
      tick();
    end
    load_frame(40'h7F_6D_66_4F_5B, 2'b00);
    advance_to(FRAME - 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      advance_to(BC);
      check("steady_glyph", 64'(seg_out), 64'h7F);
      advance_to(FRAME - 1);
      tick();
    end

    // Load on the frame_done cycle: shows one frame later
    advance_to(FRAME - 1);
    check("ready_before_fd_load", 64'(ready), 64'h1);
    load_frame(40'h11_22_33_44_55, 2'b00);
    check("ready_low_after_fd_load", 64'(ready), 64'h0);
    advance_to(BC);
    check("old_glyph_kept", 64'(seg_out), 64'h7F);
    advance_to(FRAME - 1);
    check("ready_low_until_xfer", 64'(ready), 64'h0);
    tick();
    check("ready_back_after_xfer", 64'(ready), 64'h1);
    advance_to(BC);
    check("new_glyph_shown", 64'(seg_out), 64'h11);

    // Randomized loads checked cycle by cycle against the model
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 90)) tick();
      data_in = {32'($urandom()), 8'($urandom())};
      mode_in = 2'($urandom());
      load    = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      load    = 1'b0;
    end

    // Reset mid-DRIVE of digit 3 with a full shadow
    advance_to(FRAME - 1);
    tick();
    load_frame(40'hAA_BB_CC_DD_EE, 2'b00);
    advance_to(3 * SD + BC + 3);
    check("pre_reset_digit3", 64'(seg_select), 64'h08);
    #3 reset = 1'b0;
    #1;
    check("midrst_seg_select", 64'(seg_select), 64'h0);
    check("midrst_seg_out",    64'(seg_out),    64'h0);
    check("midrst_frame_done", 64'(frame_done), 64'h0);
    check("midrst_ready",      64'(ready),      64'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    check("restart_blank", 64'(seg_select), 64'h0);
    repeat (BC) tick();
    check("restart_digit0", 64'(seg_select), 64'h01);
    check("restart_cleared", 64'(seg_out), 64'h00);
    advance_to(FRAME - 1);
    tick();
    check("shadow_discarded", 64'(ready), 64'h1);
    load_frame(40'h06_5B_4F_66_6D, 2'b00);
    repeat (2 * FRAME) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 20000, clk cycles per digit slot (1 ms at 20 MHz); SHALL be at least BLANK_CYC+4.
REQ-002 SHALL have parameter BLANK_CYC, default 200, anti-ghost blanking cycles at the start of each slot.
REQ-003 SHALL have parameter FLASH_FRAMES, default 50, frames per flash half-period.
REQ-004 SHALL have port clk, input, 1, single clock (20 MHz slow clock).
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port data_in, input, 40, five 8-bit segment glyphs; digit 0 = [39:32], digit 4 = [7:0].
REQ-007 SHALL have port mode_in, input, 2, display mode: 00 constant, 01 flash, 10 off, 11 treated as constant.
REQ-008 SHALL have port load, input, 1, frame-write strobe, qualified by ready.
REQ-009 SHALL have port ready, output, 1, high when the shadow buffer is empty.
REQ-010 SHALL have port seg_select, output, 5, one-hot active-high digit enable.
REQ-011 SHALL have port seg_out, output, 8, segment drive, active-high, bit 7 = dp.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at the end of digit-4 slot.

Function
REQ-013 SHALL run a 2-state slot FSM: BLANK for BLANK_CYC cycles with seg_select=0 and seg_out=0, then DRIVE for SCAN_DIV-BLANK_CYC cycles with the current digit driven.
REQ-014 SHALL advance the digit index 0→1→2→3→4→0 at the end of each DRIVE; wrapping from 4 to 0 SHALL pulse frame_done in the same cycle.
REQ-015 SHALL accept load only when ready=1: it captures data_in and mode_in into the shadow buffer and deasserts ready the next cycle; load while ready=0 SHALL be ignored.
REQ-016 SHALL copy shadow to active on the frame_done cycle when the shadow is full, then reassert ready the following cycle; a new frame SHALL therefore never appear mid-frame (no tearing).
REQ-017 When load with ready=1 coincides with frame_done, the data SHALL go to the shadow and become active at the next frame_done.
REQ-018 In DRIVE, seg_out SHALL equal the active glyph for the current digit in constant mode, 0 in off mode, and in flash mode the glyph during the on phase and 0 during the off phase; seg_select SHALL stay one-hot in all modes.
REQ-019 The flash phase SHALL toggle after every FLASH_FRAMES frame_done pulses; it SHALL restart at on-phase with a zero count whenever a shadow-to-active transfer changes the active mode.
REQ-020 Counter widths SHALL derive from the parameters via clog2, with no overflow at the maximum parameter values.

Reset
REQ-021 On reset low, SHALL asynchronously clear: seg_select=0, seg_out=0, frame_done=0, ready=1, digit=0, FSM=BLANK, slot/flash counters=0, flash phase=on, active and shadow data=0, active mode=constant.
REQ-022 Reset asserted mid-slot or mid-transfer SHALL discard the shadow; scanning SHALL restart at digit 0 BLANK on the first clk edge after release.

Configuration
REQ-023 With macro SEG_DIM_EN defined, SHALL add input bright[1:0]; seg_out SHALL be driven only for the first ((bright+1)*(SCAN_DIV-BLANK_CYC))/4 DRIVE cycles and SHALL be 0 for the rest; bright SHALL be sampled at each BLANK entry.
REQ-024 Without SEG_DIM_EN, the bright port and dimming logic SHALL be absent and DRIVE SHALL be full-duty.

Structure
REQ-025 Mode codes (constant/flash/off) and the blank glyph SHALL live in the shared defines package, alongside the existing seg_mode codes.
REQ-026 The slot counter and BLANK/DRIVE FSM SHALL form sub-module seg_slot_timer, which outputs the digit index, a drive flag and frame_done.

Verification (bench: SCAN_DIV=16, BLANK_CYC=4, FLASH_FRAMES=2)
REQ-027 Test: reset, then load data_in=0x3F_06_5B_4F_66 with mode 00 -> ready is low 1 cycle later; from the second frame on, digit 2 DRIVE shows seg_select=00100 and seg_out=0x5B, with 4 blank cycles per slot and frame_done every 80 cycles.
REQ-028 Test: load while ready=0 with 0xFF..FF -> ignored; the active frame stays unchanged.
REQ-029 Test: load in mode 01 -> seg_out shows glyphs for 2 frames, is 0 for 2 frames, then repeats; a mode-00 reload restores steady display.
REQ-030 Test: load asserted on the frame_done cycle -> data appears one frame later; ready reasserts the cycle after the transfer.
REQ-031 Test: assert reset mid-DRIVE of digit 3 -> all outputs are 0 and ready=1 immediately; after release, scanning restarts at digit 0 BLANK.
REQ-032 Test (SEG_DIM_EN, bright=01) -> seg_out is nonzero for 6 of 12 DRIVE cycles per slot.
